// File: rtl/tomasulo_mem_responder.sv
// tomasulo_mem_responder
// Shared RAM behind the Tomasulo core: a registered instruction read port and
// a data port with byte-lane writes, programmable wait states and a one-cycle
// ready pulse. Storage is split into four byte banks so each lane can be
// written independently while both ports read the same word index.
module tomasulo_mem_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 4096,
    parameter int DATA_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic                  inst_ce_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_we_i,
    input  logic                  mem_ce_i,
    input  logic [3:0]            mem_sel_i,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_ready_o,
    output logic                  mem_busy_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(DATA_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic [3:0]            r_sel;
    logic                  r_ready;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_inst;

    logic [IDX_W-1:0]      w_inst_idx;
    logic [IDX_W-1:0]      w_mem_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [DATA_WIDTH-1:0] w_inst_word;
    logic [DATA_WIDTH-1:0] w_data_word;
    logic                  w_wr_en;
    logic                  w_unused;

    // Word index drops the byte offset; upper bits beyond the depth alias.
    assign w_inst_idx = inst_addr_i[IDX_W+1:2];
    assign w_mem_idx  = mem_addr_i[IDX_W+1:2];

    // In IDLE the request has not been latched yet, so a latency-1 read must
    // look up the live address; afterwards only the latched index is used.
    assign w_rd_idx = (r_state == S_IDLE) ? w_mem_idx : r_idx;

    // Writes commit at the edge that ends the RESP cycle; a reset held across
    // that edge discards them.
    assign w_wr_en = (r_state == S_RESP) && r_we && !rst;

    assign w_unused = ^{inst_addr_i[ADDR_WIDTH-1:IDX_W+2], inst_addr_i[1:0],
                        mem_addr_i[ADDR_WIDTH-1:IDX_W+2], mem_addr_i[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_bank [0:DEPTH_WORDS-1];

            // Byte bank write: only lanes enabled by the latched select change.
            always_ff @(posedge clk) begin
                if (w_wr_en && r_sel[gi]) begin
                    r_bank[r_idx] <= r_wdata[8*gi +: 8];
                end
            end

            assign w_inst_word[8*gi +: 8] = r_bank[w_inst_idx];
            assign w_data_word[8*gi +: 8] = r_bank[w_rd_idx];
        end
    endgenerate

    // Instruction port: one-cycle registered read, zero when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst <= '0;
        end else if (inst_ce_i) begin
            r_inst <= w_inst_word;
        end else begin
            r_inst <= '0;
        end
    end

    // Data FSM: accept in IDLE, count wait states, pulse ready in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_ce_i) begin
                        r_idx   <= w_mem_idx;
                        r_wdata <= mem_data_i;
                        r_we    <= mem_we_i;
                        r_sel   <= mem_sel_i;
                        r_cnt   <= LAT_M1;
                        r_busy  <= 1'b1;
                        if (DATA_LATENCY == 1) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            if (!mem_we_i) begin
                                r_rdata <= w_data_word;
                            end
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!mem_ce_i) begin
                        // Initiator withdrew: abandon silently, nothing written.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt <= 4'd1) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                        if (!r_we) begin
                            r_rdata <= w_data_word;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign inst_o      = r_inst;
    assign mem_data_o  = r_rdata;
    assign mem_ready_o = r_ready;
    assign mem_busy_o  = r_busy;

endmodule

// File: doc/tomasulo_mem_responder.md
Name: tomasulo_mem_responder

Overview:
Memory-side responder for the CPU's instruction and data memory interfaces, used as the simulation/FPGA RAM behind the Tomasulo core.
- Instruction port: word read with one-cycle registered latency.
- Data port: byte-lane writes and word reads, with configurable wait states and a one-cycle ready pulse so the core's load/store path can be stalled.
- Both ports share one word-addressed storage array.

Parameters:
ADDR_WIDTH, 32, byte-address width on both ports
DATA_WIDTH, 32, word width; fixed 4 byte lanes
DEPTH_WORDS, 4096, storage depth in words; power of two
DATA_LATENCY, 2, cycles from data request accept to ready; legal range 1..15

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
inst_addr_i  in  ADDR_WIDTH  instruction byte address
inst_ce_i  in  1  instruction read enable
inst_o  out  DATA_WIDTH  instruction word, registered
mem_addr_i  in  ADDR_WIDTH  data byte address
mem_data_i  in  DATA_WIDTH  store data
mem_we_i  in  1  1 = write, 0 = read
mem_ce_i  in  1  data request; held high by initiator until mem_ready_o
mem_sel_i  in  4  byte-lane enables; bit n covers bits [8n+7:8n]
mem_data_o  out  DATA_WIDTH  load data, valid while mem_ready_o is high, held afterwards
mem_ready_o  out  1  one-cycle completion pulse for read or write
mem_busy_o  out  1  high while a data request is in flight (WAIT or RESP)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high, named rst as in the rest of the core.
- Reset: inst_o=0, mem_data_o=0, mem_ready_o=0, mem_busy_o=0, FSM=IDLE, wait counter=0. The storage array is not cleared.
- Addressing:
  - word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] are ignored.
  - Upper bits beyond the depth are ignored, so out-of-range addresses alias (wrap) into the array.
- Instruction port:
  - If inst_ce_i=1 at edge T, inst_o = array[index] during T+1.
  - If inst_ce_i=0, inst_o is 0 on the next cycle.
  - No stall; a new address is accepted every cycle.
- Data FSM, states IDLE, WAIT, RESP:
  - IDLE: when mem_ce_i=1, latch addr, data, we and sel, and load counter = DATA_LATENCY-1.
    - If DATA_LATENCY=1, go to RESP; otherwise go to WAIT.
  - WAIT: decrement counter each cycle; go to RESP when counter reaches 1.
    - If mem_ce_i drops in WAIT: abort to IDLE, no write, no ready pulse.
  - RESP: mem_ready_o=1 for exactly this cycle.
    - Read: mem_data_o = array[latched index].
    - Write: each lane with latched sel bit set is updated at the end of this cycle; unselected lanes are preserved.
    - Next state is IDLE.
- Timing: a request accepted at edge T gives mem_ready_o high during cycle T+DATA_LATENCY. The earliest next accept is at the edge ending cycle T+DATA_LATENCY+1, so peak throughput is one request per DATA_LATENCY+1 cycles.
  - If mem_ce_i is still high in the first IDLE cycle after ready, that is a new request.
- Inputs outside IDLE: changes to mem_addr_i, mem_data_i, mem_we_i and mem_sel_i after accept are ignored; only latched values are used.
- mem_busy_o: 1 in WAIT and RESP, 0 in IDLE.
- Write with sel=0: completes with a ready pulse and changes no data.
- Read-during-write, same word, same edge: the instruction read and any data read see the old contents. The write becomes visible on the following cycle.
- Reset mid-operation: an in-flight write is discarded, the FSM returns to IDLE, and no ready pulse is produced.

Test Plan:
- Reset, then data write addr 0x10, data 0xDEADBEEF, sel 4'hF, DATA_LATENCY=2 -> mem_ready_o high exactly 2 cycles after accept, busy high for those 2 cycles. Data read of 0x10 -> mem_data_o=0xDEADBEEF with its ready pulse.
- Preload word 0x10=0xDEADBEEF, write 0x00000055 with sel 4'b0001 -> subsequent read returns 0xDEADBE55. Instruction fetch of 0x10 (inst_ce_i=1) -> inst_o=0xDEADBE55 the next cycle.
- Misaligned and aliasing: write 0x12345678 to 0x13 -> read 0x10 returns 0x12345678. Write to DEPTH_WORDS*4+0x10 -> overwrites word 0x10.
- Abort and reset: drop mem_ce_i during WAIT of a write to 0x20 -> no ready pulse and 0x20 unchanged. Assert rst during WAIT of a write -> outputs 0, FSM IDLE, word unchanged.
- Back-to-back: hold mem_ce_i high across 3 reads with DATA_LATENCY=1 -> ready pulses 2 cycles apart, each with correct data. Concurrent inst fetch of the same word written in the RESP cycle -> old value returned.
